// File: rtl/video_axis_pkg.sv
// Shared definitions for the synthetic AXI4-Stream video source and its future sink/checker.
package video_axis_pkg;

    // Pattern select encodings
    localparam logic [1:0] PAT_CHECKER = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_SOLID   = 2'd2;
    localparam logic [1:0] PAT_INDEX   = 2'd3;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pattern_pixel.sv
// Combinational pixel generator: maps (x, y, pattern) to one pixel value.
module axis_pattern_pixel
    import video_axis_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned HEIGHT     = 16,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned TILE_LOG2  = 3
) (
    input  logic [cnt_bits(WIDTH)-1:0]  x,
    input  logic [cnt_bits(HEIGHT)-1:0] y,
    input  logic [1:0]                  sel,
    output logic [DATA_WIDTH-1:0]       pixel
);

    logic        tile_even;
    logic [7:0]  x8;
    logic [31:0] idx;

    // Pattern selection; ramp replicates x[7:0] into every 8-bit lane
    always_comb begin
        tile_even = (((32'(x) >> TILE_LOG2) + (32'(y) >> TILE_LOG2)) & 32'd1) == 32'd0;
        x8        = 8'(x);
        idx       = 32'(y) * 32'(WIDTH) + 32'(x);
        pixel     = '0;
        case (sel)
            PAT_CHECKER: pixel = tile_even ? '1 : '0;
            PAT_RAMP: begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    pixel[i] = x8[i % 8];
                end
            end
            PAT_SOLID:   pixel = '1;
            default:     pixel = DATA_WIDTH'(idx);
        endcase
    end

endmodule

// File: rtl/axis_video_frame_source.sv
// AXI4-Stream synthetic video frame source with tuser on (0,0), tlast per line or frame,
// full backpressure and an optional idle gap between frames.
module axis_video_frame_source
    import video_axis_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned HEIGHT         = 16,
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned TILE_LOG2      = 3,
    parameter int unsigned TLAST_PER_LINE = 0,
    parameter int unsigned FRAME_GAP      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           num_frames,
    input  logic [1:0]            pattern_sel,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    localparam int unsigned XW = cnt_bits(WIDTH);
    localparam int unsigned YW = cnt_bits(HEIGHT);
    localparam int unsigned GW = cnt_bits(FRAME_GAP + 1);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [GW-1:0] G_LAST = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic [15:0]     nfr_q, nfr_d;
    logic [1:0]      pat_q, pat_d;
    logic            abort_pend_q, abort_pend_d;
    logic            tvalid_d, busy_d, tlast_d, tuser_d;
    logic [DATA_WIDTH-1:0] tdata_d, pix_data;
    logic            load_px, clr_px;
    logic            hs, at_eof, frame_end, last_frame, gap_end;

    // Handshake and end-of-frame qualifiers from registered state
    assign hs         = m_axis_tvalid & m_axis_tready;
    assign at_eof     = (x_q == X_LAST) && (y_q == Y_LAST);
    assign frame_end  = hs & at_eof;
    assign last_frame = ((nfr_q != 16'd0) && ((fcnt_q + 16'd1) == nfr_q)) || abort_pend_q || abort;
    assign gap_end    = (gap_q == G_LAST);
    // Qualified by tready so the pulse lands on the final handshake itself
    assign frame_done = frame_end;

    axis_pattern_pixel #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .DATA_WIDTH (DATA_WIDTH),
        .TILE_LOG2  (TILE_LOG2)
    ) u_pixel (
        .x     (x_d),
        .y     (y_d),
        .sel   (pat_d),
        .pixel (pix_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SEND;
            ST_SEND: begin
                if (frame_end) begin
                    if (last_frame)         state_d = ST_IDLE;
                    else if (FRAME_GAP > 0) state_d = ST_GAP;
                    else                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (abort)        state_d = ST_IDLE;
                else if (gap_end) state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless a transition says otherwise
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        gap_d        = gap_q;
        fcnt_d       = fcnt_q;
        nfr_d        = nfr_q;
        pat_d        = pat_q;
        abort_pend_d = abort_pend_q;
        tvalid_d     = m_axis_tvalid;
        busy_d       = busy;
        load_px      = 1'b0;
        clr_px       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d        = pattern_sel;
                    nfr_d        = num_frames;
                    fcnt_d       = 16'd0;
                    abort_pend_d = 1'b0;
                    x_d          = '0;
                    y_d          = '0;
                    busy_d       = 1'b1;
                    tvalid_d     = 1'b1;
                    load_px      = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) abort_pend_d = 1'b1;
                if (frame_end) begin
                    x_d = '0;
                    y_d = '0;
                    if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
                    if (last_frame) begin
                        tvalid_d     = 1'b0;
                        busy_d       = 1'b0;
                        abort_pend_d = 1'b0;
                        clr_px       = 1'b1;
                    end else if (FRAME_GAP > 0) begin
                        tvalid_d = 1'b0;
                        gap_d    = '0;
                        clr_px   = 1'b1;
                    end else begin
                        load_px = 1'b1;
                    end
                end else if (hs) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    load_px = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    busy_d       = 1'b0;
                    abort_pend_d = 1'b0;
                end else if (gap_end) begin
                    tvalid_d = 1'b1;
                    load_px  = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
                clr_px   = 1'b1;
            end
        endcase
    end

    // Beat payload: load the next pixel, clear when going quiet, otherwise hold
    always_comb begin
        tdata_d = m_axis_tdata;
        tlast_d = m_axis_tlast;
        tuser_d = m_axis_tuser;
        if (load_px) begin
            tdata_d = pix_data;
            tuser_d = (x_d == '0) && (y_d == '0);
            tlast_d = (TLAST_PER_LINE != 0) ? (x_d == X_LAST)
                                            : ((x_d == X_LAST) && (y_d == Y_LAST));
        end else if (clr_px) begin
            tdata_d = '0;
            tlast_d = 1'b0;
            tuser_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            gap_q         <= '0;
            fcnt_q        <= 16'd0;
            nfr_q         <= 16'd0;
            pat_q         <= 2'd0;
            abort_pend_q  <= 1'b0;
            busy          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            gap_q         <= gap_d;
            fcnt_q        <= fcnt_d;
            nfr_q         <= nfr_d;
            pat_q         <= pat_d;
            abort_pend_q  <= abort_pend_d;
            busy          <= busy_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tuser  <= tuser_d;
        end
    end

endmodule

// File: tb/tb_axis_video_frame_source.sv
// Scoreboard bench for axis_video_frame_source: two instances (no gap / tlast per frame,
// and 4-cycle gap / tlast per line) share stimulus; each has its own expected-beat queue.
module tb_axis_video_frame_source;

    localparam int W    = 32;
    localparam int H    = 16;
    localparam int TILE = 8;

    typedef struct packed {
        logic [23:0] data;
        logic        last;
        logic        user;
        logic        eof;
        logic        fin;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_frames;
    logic [1:0]  pattern_sel;
    logic        tready;
    logic        rnd_ready;

    logic        dv_busy   [2];
    logic        dv_fd     [2];
    logic [23:0] dv_tdata  [2];
    logic        dv_tvalid [2];
    logic        dv_tlast  [2];
    logic        dv_tuser  [2];

    beat_t exp_q [2][$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[inst%0d] @%0t: got %h expected %h", name, g, $time, act, exp);
        end
    endtask

    // Reference pixel from the pattern definitions using plain arithmetic
    function automatic logic [23:0] model_pix(input int pat, input int x, input int y);
        case (pat)
            0:       return ((((x / TILE) + (y / TILE)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            1:       return 24'(x % 256) * 24'h010101;
            2:       return 24'hFFFFFF;
            default: return 24'((y * W + x) % (1 << 24));
        endcase
    endfunction

    // Queue the full expected beat stream of n frames for instance g
    task automatic push_frames(input int g, input int pat, input int n, input bit fin);
        beat_t b;
        for (int f = 0; f < n; f++) begin
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    b.data = model_pix(pat, x, y);
                    b.user = (x == 0) && (y == 0);
                    b.eof  = (x == W - 1) && (y == H - 1);
                    b.last = (g == 1) ? (x == W - 1) : b.eof;
                    b.fin  = fin && b.eof && (f == n - 1);
                    exp_q[g].push_back(b);
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [1:0] pat, input logic [15:0] nfr);
        @(posedge clk);
        #1;
        pattern_sel = pat;
        num_frames  = nfr;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 6000 && !(exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                             !dv_busy[0] && !dv_busy[1])) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 0, 32'(n >= 6000), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Sink ready: held high or randomised each cycle
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned GAP  = (g == 1) ? 4 : 0;
        localparam int unsigned TLPL = (g == 1) ? 1 : 0;

        logic        pstall, fin_chk, first_chk, gap_arm;
        logic [23:0] pdata;
        logic        plast, puser;
        int          idle_cnt;

        axis_video_frame_source #(
            .WIDTH          (W),
            .HEIGHT         (H),
            .DATA_WIDTH     (24),
            .TILE_LOG2      (3),
            .TLAST_PER_LINE (TLPL),
            .FRAME_GAP      (GAP)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start),
            .abort         (abort),
            .num_frames    (num_frames),
            .pattern_sel   (pattern_sel),
            .busy          (dv_busy[g]),
            .frame_done    (dv_fd[g]),
            .m_axis_tdata  (dv_tdata[g]),
            .m_axis_tvalid (dv_tvalid[g]),
            .m_axis_tready (tready),
            .m_axis_tlast  (dv_tlast[g]),
            .m_axis_tuser  (dv_tuser[g])
        );

        // Monitor: compares every handshake against the scoreboard and checks protocol timing
        initial begin
            beat_t e;
            pstall = 1'b0; fin_chk = 1'b0; first_chk = 1'b0; gap_arm = 1'b0; idle_cnt = 0;
            pdata = '0; plast = 1'b0; puser = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    pstall = 1'b0; fin_chk = 1'b0; first_chk = 1'b0; gap_arm = 1'b0;
                end else begin
                    if (first_chk) begin
                        chk("first_beat_valid", g, 32'(dv_tvalid[g]), 32'd1);
                        chk("first_beat_tuser", g, 32'(dv_tuser[g]), 32'd1);
                        first_chk = 1'b0;
                    end
                    if (fin_chk) begin
                        chk("idle_after_last", g, {30'd0, dv_tvalid[g], dv_busy[g]}, 32'd0);
                        fin_chk = 1'b0;
                    end
                    if (gap_arm) begin
                        if (dv_tvalid[g]) begin
                            chk("frame_gap", g, 32'(idle_cnt), 32'(GAP));
                            gap_arm = 1'b0;
                        end else begin
                            idle_cnt++;
                        end
                    end
                    if (pstall) begin
                        chk("stall_hold", g, {6'd0, dv_tvalid[g], dv_tdata[g], dv_tlast[g]},
                            {6'd0, 1'b1, pdata, plast});
                        chk("stall_tuser", g, 32'(dv_tuser[g]), 32'(puser));
                    end
                    if (dv_tvalid[g] && tready) begin
                        if (exp_q[g].size() == 0) begin
                            chk("unexpected_beat", g, 32'd1, 32'd0);
                        end else begin
                            e = exp_q[g].pop_front();
                            chk("tdata", g, 32'(dv_tdata[g]), 32'(e.data));
                            chk("tlast", g, 32'(dv_tlast[g]), 32'(e.last));
                            chk("tuser", g, 32'(dv_tuser[g]), 32'(e.user));
                            chk("frame_done", g, 32'(dv_fd[g]), 32'(e.eof));
                            if (e.eof && exp_q[g].size() != 0) begin
                                gap_arm  = 1'b1;
                                idle_cnt = 0;
                            end
                            if (e.fin) fin_chk = 1'b1;
                        end
                    end else begin
                        chk("frame_done_idle", g, 32'(dv_fd[g]), 32'd0);
                    end
                    pstall = dv_tvalid[g] && !tready;
                    pdata  = dv_tdata[g];
                    plast  = dv_tlast[g];
                    puser  = dv_tuser[g];
                    if (start && !dv_busy[g]) begin
                        first_chk = 1'b1;
                        gap_arm   = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_frames = 16'd0;
        pattern_sel = 2'd0; rnd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_tvalid", g, 32'(dv_tvalid[g]), 32'd0);
            chk("rst_busy",   g, 32'(dv_busy[g]),   32'd0);
            chk("rst_tuser",  g, 32'(dv_tuser[g]),  32'd0);
            chk("rst_tlast",  g, 32'(dv_tlast[g]),  32'd0);
            chk("rst_tdata",  g, 32'(dv_tdata[g]),  32'd0);
            chk("rst_fdone",  g, 32'(dv_fd[g]),     32'd0);
        end
        rst_n = 1'b1;

        // Checkerboard, single frame, sink always ready
        for (int g = 0; g < 2; g++) push_frames(g, 0, 1, 1'b1);
        pulse_start(2'd0, 16'd1);
        wait_done();

        // Pixel index under random backpressure
        rnd_ready = 1'b1;
        for (int g = 0; g < 2; g++) push_frames(g, 3, 1, 1'b1);
        pulse_start(2'd3, 16'd1);
        wait_done();

        // Ramp, three frames, random backpressure; exercises inter-frame gap
        for (int g = 0; g < 2; g++) push_frames(g, 1, 3, 1'b1);
        pulse_start(2'd1, 16'd3);
        wait_done();

        // Solid, two frames, always ready
        rnd_ready = 1'b0;
        for (int g = 0; g < 2; g++) push_frames(g, 2, 2, 1'b1);
        pulse_start(2'd2, 16'd2);
        wait_done();

        // Continuous mode: stray start and pattern change in frame 1, abort mid frame 2
        for (int g = 0; g < 2; g++) push_frames(g, 0, 2, 1'b1);
        pulse_start(2'd0, 16'd0);
        repeat (49) @(posedge clk);
        #1;
        start = 1'b1;
        pattern_sel = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (613 - 51 - 1) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done();

        // Continuous mode, abort lands in the gap of the gapped instance
        push_frames(0, 2, 2, 1'b1);
        push_frames(1, 2, 1, 1'b0);
        pulse_start(2'd2, 16'd0);
        repeat (513) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("gap_abort_busy", 1, 32'(dv_busy[1]), 32'd0);
        chk("gap_abort_busy", 0, 32'(dv_busy[0]), 32'd1);
        wait_done();

        // Asynchronous reset in the middle of a frame, then a fresh start
        for (int g = 0; g < 2; g++) push_frames(g, 3, 1, 1'b1);
        pulse_start(2'd3, 16'd1);
        repeat (99) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("async_rst_tvalid", g, 32'(dv_tvalid[g]), 32'd0);
            chk("async_rst_busy",   g, 32'(dv_busy[g]),   32'd0);
            chk("async_rst_tuser",  g, 32'(dv_tuser[g]),  32'd0);
            exp_q[g].delete();
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("post_rst_idle", g, {30'd0, dv_tvalid[g], dv_busy[g]}, 32'd0);
        end
        for (int g = 0; g < 2; g++) push_frames(g, 3, 1, 1'b1);
        pulse_start(2'd3, 16'd1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
